// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: FSM encoding, default widths and the EX/MEM
// control bundle used by both the execute unit and the memory access unit.
package mem_access_unit_pkg;

  localparam int         DATA_W = 32;
  localparam logic [4:0] SP_REG = 5'b11101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic mem_src;
    logic call;
    logic ret;
  } exmem_ctrl_t;

  // A call pushes the PC, so it always behaves as a store.
  function automatic logic eff_write(input exmem_ctrl_t c);
    return c.mem_write | c.call;
  endfunction

  function automatic logic is_mem_op(input exmem_ctrl_t c);
    return c.mem_read | eff_write(c);
  endfunction

endpackage

// File: rtl/mem_access_unit_exmem_reg.sv
// EX/MEM pipeline register: loads whenever not stalled, and an invalid
// EX bundle becomes a bubble with every enable cleared.
module mem_access_unit_exmem_reg #(
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_i,
  input  mem_access_unit_pkg::exmem_ctrl_t  ctrl_i,
  input  logic [4:0]                        dest_i,
  input  logic [DATA_W-1:0]                 alu_addr_i,
  input  logic [DATA_W-1:0]                 non_alu_addr_i,
  input  logic [DATA_W-1:0]                 wdata_i,
  output mem_access_unit_pkg::exmem_ctrl_t  ctrl_o,
  output logic [4:0]                        dest_o,
  output logic [DATA_W-1:0]                 alu_addr_o,
  output logic [DATA_W-1:0]                 non_alu_addr_o,
  output logic [DATA_W-1:0]                 wdata_o
);
  import mem_access_unit_pkg::*;

  exmem_ctrl_t       ctrl_q, ctrl_d;
  logic [4:0]        dest_q;
  logic [DATA_W-1:0] alu_q, non_alu_q, wdata_q;

  always_comb begin
    ctrl_d = '0;
    if (ctrl_i.valid) begin
      ctrl_d = ctrl_i;
    end else begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      dest_q    <= 5'd0;
      alu_q     <= {DATA_W{1'b0}};
      non_alu_q <= {DATA_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
    end else if (load_i) begin
      ctrl_q    <= ctrl_d;
      dest_q    <= dest_i;
      alu_q     <= alu_addr_i;
      non_alu_q <= non_alu_addr_i;
      wdata_q   <= wdata_i;
    end
  end

  assign ctrl_o         = ctrl_q;
  assign dest_o         = dest_q;
  assign alu_addr_o     = alu_q;
  assign non_alu_addr_o = non_alu_q;
  assign wdata_o        = wdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: EX/MEM capture, req/ack data-memory sequencing with timeout,
// write-back, forwarding and return-address delivery.
module mem_access_unit #(
  parameter int         DATA_W      = mem_access_unit_pkg::DATA_W,
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [4:0] SP_REG      = mem_access_unit_pkg::SP_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_stall,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemToReg_in,
  input  logic              MemSrc_in,
  input  logic              call_in,
  input  logic              ret_in,
  input  logic [4:0]        DestReg_in,
  input  logic [DATA_W-1:0] ALU_addr_in,
  input  logic [DATA_W-1:0] NON_ALU_addr_in,
  input  logic [DATA_W-1:0] MemWrite_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              RegWrite_out,
  output logic [4:0]        DestReg_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] EXMEM_ALU_addr,
  output logic [DATA_W-1:0] MEM_ALUfrwd_data,
  output logic [DATA_W-1:0] MEM_Memfrwd_data,
  output logic              ret_valid,
  output logic [DATA_W-1:0] ret_target,
  output logic              mem_timeout_err
);
  import mem_access_unit_pkg::*;

  localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 1 || SP_REG == 5'd0) begin : g_bad_param
    $error("mem_access_unit: MEM_TIMEOUT must be >= 1 and SP_REG must be nonzero");
  end

  exmem_ctrl_t       ctrl_in_s, exm_ctrl_s;
  logic [4:0]        exm_dest_s;
  logic [DATA_W-1:0] exm_alu_s, exm_non_alu_s, exm_wdata_s;

  mau_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              in_wait_s, in_done_s;

  assign ctrl_in_s = {ex_valid, RegWrite_in, MemWrite_in, MemRead_in,
                      MemToReg_in, MemSrc_in, call_in, ret_in};
  assign in_wait_s = (state_q == WAIT);
  assign in_done_s = (state_q == DONE);

  mem_access_unit_exmem_reg #(.DATA_W(DATA_W)) u_exmem_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_i         (~in_wait_s),
    .ctrl_i         (ctrl_in_s),
    .dest_i         (DestReg_in),
    .alu_addr_i     (ALU_addr_in),
    .non_alu_addr_i (NON_ALU_addr_in),
    .wdata_i        (MemWrite_data_in),
    .ctrl_o         (exm_ctrl_s),
    .dest_o         (exm_dest_s),
    .alu_addr_o     (exm_alu_s),
    .non_alu_addr_o (exm_non_alu_s),
    .wdata_o        (exm_wdata_s)
  );

  // IDLE/DONE decide on the incoming bundle so mem_req rises right after capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        tmo_d = 1'b0;
        if (ex_valid && is_mem_op(ctrl_in_s)) begin
          state_d = WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          rdata_d = eff_write(exm_ctrl_s) ? {DATA_W{1'b0}} : mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = {DATA_W{1'b0}};
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign ex_stall  = in_wait_s;
  assign mem_req   = in_wait_s;
  assign mem_we    = in_wait_s & eff_write(exm_ctrl_s);
  assign mem_addr  = exm_ctrl_s.mem_src ? exm_non_alu_s : exm_alu_s;
  assign mem_wdata = exm_wdata_s;

  assign wb_valid     = in_done_s | ((state_q == IDLE) & exm_ctrl_s.valid & ~is_mem_op(exm_ctrl_s));
  assign wb_data      = (in_done_s & exm_ctrl_s.mem_to_reg) ? rdata_q : exm_alu_s;
  assign RegWrite_out = exm_ctrl_s.valid & exm_ctrl_s.reg_write & wb_valid & ~(in_done_s & tmo_q);
  assign DestReg_out  = exm_dest_s;

  assign EXMEM_ALU_addr   = exm_alu_s;
  assign MEM_ALUfrwd_data = exm_alu_s;
  assign MEM_Memfrwd_data = rdata_q;

  assign ret_valid       = in_done_s & exm_ctrl_s.valid & exm_ctrl_s.ret;
  assign ret_target      = rdata_q;
  assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU op, load, call, read+write, ret,
// timeout and mid-access asynchronous reset, with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_stall;
  logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, call_in, ret_in;
  logic [4:0]  DestReg_in, DestReg_out;
  logic [31:0] ALU_addr_in, NON_ALU_addr_in, MemWrite_data_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, RegWrite_out, ret_valid, mem_timeout_err;
  logic [31:0] wb_data, EXMEM_ALU_addr, MEM_ALUfrwd_data, MEM_Memfrwd_data, ret_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .MEM_TIMEOUT(4), .SP_REG(5'b11101)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in), .MemSrc_in(MemSrc_in), .call_in(call_in), .ret_in(ret_in),
    .DestReg_in(DestReg_in), .ALU_addr_in(ALU_addr_in), .NON_ALU_addr_in(NON_ALU_addr_in),
    .MemWrite_data_in(MemWrite_data_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .RegWrite_out(RegWrite_out), .DestReg_out(DestReg_out),
    .wb_data(wb_data), .EXMEM_ALU_addr(EXMEM_ALU_addr), .MEM_ALUfrwd_data(MEM_ALUfrwd_data),
    .MEM_Memfrwd_data(MEM_Memfrwd_data), .ret_valid(ret_valid), .ret_target(ret_target),
    .mem_timeout_err(mem_timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic rw, input logic mw, input logic mr,
                        input logic m2r, input logic msrc, input logic cl, input logic rt,
                        input logic [4:0] dest, input logic [31:0] alu,
                        input logic [31:0] nalu, input logic [31:0] wd);
    ex_valid = v;  RegWrite_in = rw; MemWrite_in = mw; MemRead_in = mr;
    MemToReg_in = m2r; MemSrc_in = msrc; call_in = cl; ret_in = rt;
    DestReg_in = dest; ALU_addr_in = alu; NON_ALU_addr_in = nalu; MemWrite_data_in = wd;
  endtask

  task automatic clr_op();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    clr_op();

    // Reset state
    #12;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_ex_stall", ex_stall, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_ret_valid", ret_valid, 1'b0);
    chk1("rst_tmo_err", mem_timeout_err, 1'b0);
    chk("rst_exmem_addr", EXMEM_ALU_addr, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // ALU op, latency 1
    @(negedge clk); set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h12, 32'h0, 32'h0);
    @(negedge clk);
    chk1("alu_wb_valid", wb_valid, 1'b1);
    chk("alu_wb_data", wb_data, 32'h12);
    chk("alu_dest", 32'(DestReg_out), 32'd3);
    chk1("alu_regwrite", RegWrite_out, 1'b1);
    chk1("alu_mem_req", mem_req, 1'b0);
    chk1("alu_ex_stall", ex_stall, 1'b0);
    chk("alu_frwd", MEM_ALUfrwd_data, 32'h12);
    clr_op();
    @(negedge clk);
    chk1("bubble_wb_valid", wb_valid, 1'b0);
    chk1("bubble_regwrite", RegWrite_out, 1'b0);

    // Load, ack in the 3rd WAIT cycle; a new EX op during the stall is ignored
    @(negedge clk); set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h100, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 32'hBAD, 32'h0, 32'h0);
      chk1("ld_mem_req", mem_req, 1'b1);
      chk1("ld_ex_stall", ex_stall, 1'b1);
      chk("ld_mem_addr", mem_addr, 32'h100);
      chk1("ld_mem_we", mem_we, 1'b0);
      chk1("ld_wait_wb_valid", wb_valid, 1'b0);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
    end
    @(negedge clk); mem_ack = 1'b0; clr_op();
    chk1("ld_done_req", mem_req, 1'b0);
    chk1("ld_done_stall", ex_stall, 1'b0);
    chk1("ld_done_wb_valid", wb_valid, 1'b1);
    chk("ld_done_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_done_memfrwd", MEM_Memfrwd_data, 32'hDEADBEEF);
    chk("ld_done_dest", 32'(DestReg_out), 32'd5);
    chk1("ld_done_regwrite", RegWrite_out, 1'b1);
    chk1("ld_done_ret_valid", ret_valid, 1'b0);
    @(negedge clk);
    chk1("ld_after_wb_valid", wb_valid, 1'b0);
    chk1("ld_after_req", mem_req, 1'b0);

    // Call: store PC to the stack address, ack after one cycle
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h7, 32'h3F0, 32'h40);
    @(negedge clk); clr_op();
    chk1("call_req", mem_req, 1'b1);
    chk1("call_we", mem_we, 1'b1);
    chk("call_addr", mem_addr, 32'h3F0);
    chk("call_wdata", mem_wdata, 32'h40);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    @(negedge clk); mem_ack = 1'b0;
    chk1("call_done_wb_valid", wb_valid, 1'b1);
    chk1("call_done_regwrite", RegWrite_out, 1'b0);
    chk("call_done_memfrwd", MEM_Memfrwd_data, 32'h0);
    chk("call_done_wb_data", wb_data, 32'h7);
    chk1("call_done_req", mem_req, 1'b0);

    // Read and write together: the write wins, read data is dropped
    @(negedge clk); set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h10, 32'h0, 32'hAB);
    @(negedge clk); clr_op();
    chk1("rw_we", mem_we, 1'b1);
    chk("rw_addr", mem_addr, 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'hAA;
    @(negedge clk); mem_ack = 1'b0;
    chk("rw_done_wb_data", wb_data, 32'h0);
    chk1("rw_done_regwrite", RegWrite_out, 1'b1);

    // Ret, with the next ALU op captured at the DONE edge
    @(negedge clk); set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h3F0, 32'h0, 32'h0);
    @(negedge clk); clr_op();
    chk1("ret_wait_ret_valid", ret_valid, 1'b0);
    chk("ret_addr", mem_addr, 32'h3F0);
    mem_ack = 1'b1; mem_rdata = 32'h44;
    @(negedge clk); mem_ack = 1'b0;
    chk1("ret_valid", ret_valid, 1'b1);
    chk("ret_target", ret_target, 32'h44);
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h99, 32'h0, 32'h0);
    @(negedge clk); clr_op();
    chk1("ret_pulse_end", ret_valid, 1'b0);
    chk1("b2b_wb_valid", wb_valid, 1'b1);
    chk("b2b_wb_data", wb_data, 32'h99);
    chk("b2b_dest", 32'(DestReg_out), 32'd7);
    chk1("b2b_req", mem_req, 1'b0);

    // Timeout (MEM_TIMEOUT=4): no ack on a load with RegWrite
    @(negedge clk); set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h200, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) clr_op();
      chk1("tmo_req", mem_req, 1'b1);
      chk1("tmo_err_early", mem_timeout_err, 1'b0);
    end
    @(negedge clk);
    chk1("tmo_done_req", mem_req, 1'b0);
    chk1("tmo_done_wb_valid", wb_valid, 1'b1);
    chk("tmo_done_wb_data", wb_data, 32'h0);
    chk1("tmo_done_regwrite", RegWrite_out, 1'b0);
    chk1("tmo_err_set", mem_timeout_err, 1'b1);
    @(negedge clk);
    chk1("tmo_err_sticky", mem_timeout_err, 1'b1);
    chk1("tmo_after_wb_valid", wb_valid, 1'b0);

    // Asynchronous reset in the 2nd WAIT cycle
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h300, 32'h0, 32'h0);
    @(negedge clk); clr_op();
    chk1("arst_wait1_req", mem_req, 1'b1);
    @(negedge clk);
    chk1("arst_wait2_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("arst_req", mem_req, 1'b0);
    chk1("arst_stall", ex_stall, 1'b0);
    chk1("arst_wb_valid", wb_valid, 1'b0);
    chk1("arst_err", mem_timeout_err, 1'b0);
    chk("arst_exmem", EXMEM_ALU_addr, 32'h0);
    chk("arst_dest", 32'(DestReg_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk1("arst_no_replay_req", mem_req, 1'b0);
    chk1("arst_no_replay_stall", ex_stall, 1'b0);
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h5A, 32'h0, 32'h0);
    @(negedge clk); clr_op();
    chk1("post_rst_wb_valid", wb_valid, 1'b1);
    chk("post_rst_wb_data", wb_data, 32'h5A);
    chk("post_rst_dest", 32'(DestReg_out), 32'd2);
    chk1("post_rst_regwrite", RegWrite_out, 1'b1);
    chk1("post_rst_req", mem_req, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
